// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte-stream requesters,
// with per-message lock and tx_start/tx_busy handshake sequencing.
module uart_tx_sched #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned LOCK_IDLE   = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  output logic [2:0]          grant_id,
  output logic                locked,
  output logic                err_timeout
);

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > LOCK_IDLE) ? ACK_TIMEOUT : LOCK_IDLE;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_IDLE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_ACC  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    sel;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          sel_last;

  // Locked: only the owner is eligible. Unlocked: first valid from grant_id+1 onward.
  always_comb begin
    sel       = grant_id;
    sel_valid = 1'b0;
    if (locked) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_id == 3'(i)) sel_valid = req_valid[i];
      end
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!sel_valid && req_valid[i] && ((32'(grant_id) + k) % NREQ) == i) begin
            sel_valid = 1'b1;
            sel       = 3'(i);
          end
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == 3'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // Gated by rst_n so req_ready drops the instant reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && (state == S_IDLE) && sel_valid && (sel == 3'(i));
    end
  end

  assign tx_start = (state == S_LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tx_data     <= '0;
      grant_id    <= 3'(NREQ - 1);
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            tx_data  <= sel_data;
            grant_id <= sel;
            locked   <= ~sel_last;
            cnt      <= '0;
            state    <= S_LAUNCH;
          end else if (locked) begin
            if (cnt == LOCK_LAST) begin
              locked <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          // Counter is cleared on every exit so the lock-idle count starts fresh.
          if (tx_busy) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (cnt == ACK_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: queued requester bytes, a uart_tx busy
// model, and per-scenario tasks comparing launched bytes against expectations.
module tb_uart_tx_sched;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned FRAME = 10;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [2:0]        grant_id;
  logic              locked;
  logic              err_timeout;

  int checks = 0;
  int errors = 0;
  int multi  = 0;
  int bcnt;
  bit busy_en = 1'b1;
  logic [NREQ-1:0] fire;

  // Requester queues hold {last, data}; scoreboard entries are {locked, grant_id, data}.
  logic [8:0]  rq0[$];
  logic [8:0]  rq1[$];
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  uart_tx_sched #(.NREQ(NREQ), .ACK_TIMEOUT(16), .LOCK_IDLE(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_start && busy_en) begin
      tx_busy <= 1'b1;
      bcnt    <= FRAME;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fire      = '0;
    forever begin
      @(negedge clk);
      if (fire[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (fire[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid[0] = (rq0.size() > 0);
      req_valid[1] = (rq1.size() > 0);
      if (rq0.size() > 0) {req_last[0], req_data[7:0]}  = rq0[0];
      if (rq1.size() > 0) {req_last[1], req_data[15:8]} = rq1[0];
      #4;
      fire = req_valid & req_ready;
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_start) obs_q.push_back({locked, grant_id, tx_data});
    if ($countones(req_ready) > 1) multi++;
  end

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    busy_en = 1'b1;
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rq0.push_back({1'b1, 8'h5A});
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL reset_grant got %0d exp 1", grant_id); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
    rq0.delete();
  endtask

  task automatic test_single();
    logic [11:0] e, o;
    bit ok;
    apply_reset();
    rq0.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b0, 3'd0, 8'h41});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (req_valid[0]) break;
    end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    @(posedge clk);
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h exp 41", tx_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_locked got %b exp 0", locked); end
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait got %0d bytes exp 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] e, o;
    bit ok;
    apply_reset();
    rq0.push_back({1'b1, 8'h10}); rq0.push_back({1'b1, 8'h11});
    rq1.push_back({1'b1, 8'h20}); rq1.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b0, 3'd0, 8'h10});
    exp_q.push_back({1'b0, 3'd1, 8'h20});
    exp_q.push_back({1'b0, 3'd0, 8'h11});
    exp_q.push_back({1'b0, 3'd1, 8'h21});
    wait_obs(4, 120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_wait got %0d bytes exp 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rr_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_back_to_back_lock();
    logic [11:0] e, o;
    bit ok;
    apply_reset();
    rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b1, 8'h42});
    rq1.push_back({1'b1, 8'h31});
    exp_q.push_back({1'b1, 3'd0, 8'h41});
    exp_q.push_back({1'b0, 3'd0, 8'h42});
    exp_q.push_back({1'b0, 3'd1, 8'h31});
    wait_obs(3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_wait got %0d bytes exp 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL lock_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] e, o;
    bit ok;
    bit seen;
    apply_reset();
    busy_en = 1'b0;
    rq0.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 3'd0, 8'h55});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = tx_start;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_start got 0 exp 1"); end
    repeat (16) @(posedge clk);
    #1;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_early got %b exp 0", err_timeout); end
    @(posedge clk);
    #1;
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err_timeout); end
    rq0.push_back({1'b1, 8'h56});
    exp_q.push_back({1'b0, 3'd0, 8'h56});
    wait_obs(2, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait got %0d bytes exp 2", obs_q.size()); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL to_byte got %h exp %h", o, e); end
    end
    busy_en = 1'b1;
  endtask

  task automatic test_lock_idle();
    logic [11:0] e, o;
    bit ok;
    int n;
    apply_reset();
    rq1.push_back({1'b0, 8'h61});
    exp_q.push_back({1'b1, 3'd1, 8'h61});
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_first got %0d bytes exp 1", obs_q.size()); end
    rq0.push_back({1'b1, 8'h71});
    exp_q.push_back({1'b0, 3'd0, 8'h71});
    n = 0;
    while (locked && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n < 4096 || n > 4120) begin errors++; $display("FAIL idle_hold got %0d cycles exp 4096..4120", n); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL idle_regrant got %b exp 01", req_ready); end
    wait_obs(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_wait got %0d bytes exp 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL idle_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] e, o;
    bit ok;
    apply_reset();
    rq0.push_back({1'b0, 8'h81});
    exp_q.push_back({1'b1, 3'd0, 8'h81});
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_first got %0d bytes exp 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL mid_byte got %h exp %h", o, e); end
    end
    rq0.push_back({1'b1, 8'h82});
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_start got %b exp 0", tx_start); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %b exp 0", locked); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready got %b exp 00", req_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", tx_data); end
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL mid_grant got %0d exp 1", grant_id); end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 3'd0, 8'h82});
    wait_obs(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_after got %0d bytes exp 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL mid_after_byte got %h exp %h", o, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_lock();
    test_timeout();
    test_lock_idle();
    test_reset_mid_frame();
    checks++; if (multi !== 0) begin errors++; $display("FAIL onehot_ready got %0d multi-grant cycles exp 0", multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
